// File: rtl/imm_encoder.sv
// imm_encoder: inserts a 32-bit immediate into a base instruction word
// (I/S/B/U formats), flags immediates the format cannot represent, and
// buffers the encoded words in a small FIFO drained by valid/ready.
// Every output word carries its word address.
module imm_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] base_code,
    input  logic [31:0] imm,
    input  logic [1:0]  immSel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_code,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic        err_sticky,
    input  logic        err_clr
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit tells full from empty when the index bits match.
    logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   wr_ptr_next, rd_ptr_next;
    logic [32:0]   mem [DEPTH];          // {err, code}

    logic [31:0]   enc_code;
    logic          enc_err;
    logic          full, empty, push, pop;
    logic          head_load;
    logic [32:0]   head_data;

    logic [31:0]   out_code_reg, out_addr_reg;
    logic          out_err_reg, err_sticky_reg;

    // Encode the immediate into the selected format's bit positions.
    always_comb begin
        enc_code = base_code;
        unique case (immSel)
            2'b00: enc_code[31:20] = imm[11:0];
            2'b01: begin
                enc_code[31:25] = imm[11:5];
                enc_code[11:7]  = imm[4:0];
            end
            2'b10: begin
                enc_code[31]    = imm[11];
                enc_code[7]     = imm[10];
                enc_code[30:25] = imm[9:4];
                enc_code[11:8]  = imm[3:0];
            end
            default: enc_code[31:12] = imm[31:12];
        endcase
    end

    // Range check: I/S/B need a signed 12-bit value, U needs zero low bits.
    always_comb begin
        if (immSel == 2'b11)
            enc_err = |imm[11:0];
        else
            enc_err = !((&imm[31:11]) || !(|imm[31:11]));
    end

    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign push  = in_valid && !full;
    assign pop   = out_ready && !empty;

    assign wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, push};
    assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop};

    // Pick what the output registers will hold next cycle: the new head
    // entry, or the word being written right now when it becomes the head.
    always_comb begin
        head_load = 1'b0;
        head_data = {out_err_reg, out_code_reg};
        if (wr_ptr_next != rd_ptr_next) begin
            head_load = 1'b1;
            if (push && (rd_ptr_next == wr_ptr_reg))
                head_data = {enc_err, enc_code};
            else
                head_data = mem[rd_ptr_next[AW-1:0]];
        end
    end

    // Storage array; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg[AW-1:0]] <= {enc_err, enc_code};
    end

    // Pointers, registered head word, address counter and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            out_code_reg   <= 32'h0;
            out_err_reg    <= 1'b0;
            out_addr_reg   <= BASE_ADDR;
            err_sticky_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            if (head_load) begin
                out_err_reg  <= head_data[32];
                out_code_reg <= head_data[31:0];
            end
            if (pop)
                out_addr_reg <= out_addr_reg + 32'd4;
            if (push && enc_err)
                err_sticky_reg <= 1'b1;
            else if (err_clr)
                err_sticky_reg <= 1'b0;
        end
    end

    assign in_ready   = !full;
    assign out_valid  = !empty;
    assign out_code   = out_code_reg;
    assign out_err    = out_err_reg;
    assign out_addr   = out_addr_reg;
    assign err_sticky = err_sticky_reg;

endmodule
